// File: rtl/led_pkg.sv
// Shared constants and types for the LED trail fader.
// These are the default sizing values. The top module takes them as parameter defaults.
package led_pkg;

    localparam int N_LEDS  = 12;
    localparam int LVL_W   = 4;
    localparam int LVL_MAX = (1 << LVL_W) - 1;

    typedef logic [LVL_W-1:0] level_t;

endpackage

// File: rtl/rise_detect.sv
// Turns a level signal in the clk domain into a single-cycle strobe.
// 'rise' is the combinational edge for same-cycle use.
// 'pulse_q' is the registered copy for observation.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise,
    output logic pulse_q
);

    logic prev_q;

    assign rise = in & ~prev_q;

    // Remember the previous level and register the strobe; reset wins over both.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= in;
            pulse_q <= rise;
        end
    end

endmodule

// File: rtl/led_trail_fader.sv
// Comet-trail fader placed between the bouncing-light stage and the LED pins.
// A lit LED is held at full brightness. Once it goes dark, its level is shifted
// down on every pattern step, and the level is shown through a shared PWM counter.
module led_trail_fader
    import led_pkg::*;
#(
    parameter int N_LEDS      = led_pkg::N_LEDS,
    parameter int LVL_W       = led_pkg::LVL_W,
    parameter int DECAY_SHIFT = 1,
    parameter int PWM_DIV     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_clk,
    input  logic [N_LEDS-1:0] pattern_in,
    output logic [N_LEDS-1:0] led_out,
    output logic              step_pulse
);

    localparam int                 PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [LVL_W-1:0]   LVL_FULL = {LVL_W{1'b1}};
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PWM_DIV - 1);

    logic              stepRise;
    logic [LVL_W-1:0]  level_q [N_LEDS];
    logic [LVL_W-1:0]  level_d [N_LEDS];
    logic [N_LEDS-1:0] ledOut_q;
    logic [N_LEDS-1:0] ledOut_d;
    logic [PRE_W-1:0]  prescale_q;
    logic [PRE_W-1:0]  prescale_d;
    logic [LVL_W-1:0]  pwmCnt_q;
    logic [LVL_W-1:0]  pwmCnt_d;
    logic              pwmTick;

    rise_detect u_step_rise (
        .clk     (clk),
        .rst     (rst),
        .in      (step_clk),
        .rise    (stepRise),
        .pulse_q (step_pulse)
    );

    // Prescaler wraps every PWM_DIV cycles. The PWM counter advances on each wrap.
    // When PWM_DIV is 1 the prescaler stays at 0 and the PWM counter advances on every cycle.
    always_comb begin
        prescale_d = prescale_q + 1'b1;
        pwmTick    = 1'b0;
        if (prescale_q == PRE_LAST) begin
            prescale_d = '0;
            pwmTick    = 1'b1;
        end
        pwmCnt_d = pwmTick ? (pwmCnt_q + 1'b1) : pwmCnt_q;
    end

    // Per-LED next state, in priority order:
    //   1. A lit pattern bit forces full brightness.
    //   2. Otherwise a step shifts the level down.
    //   3. Otherwise the level holds.
    // Full level is shown as solid on. Other levels are compared against the PWM counter.
    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        assign level_d[i]  = pattern_in[i] ? LVL_FULL
                           : (stepRise ? (level_q[i] >> DECAY_SHIFT) : level_q[i]);
        assign ledOut_d[i] = (level_q[i] == LVL_FULL) | (level_q[i] > pwmCnt_q);
    end

    // Register the levels, the PWM timebase and the LED drive; reset clears the whole trail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                level_q[i] <= '0;
            end
            prescale_q <= '0;
            pwmCnt_q   <= '0;
            ledOut_q   <= '0;
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                level_q[i] <= level_d[i];
            end
            prescale_q <= prescale_d;
            pwmCnt_q   <= pwmCnt_d;
            ledOut_q   <= ledOut_d;
        end
    end

    assign led_out = ledOut_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// Testbench for led_trail_fader.
// Directed scenarios run on a fast-PWM instance.
// A randomized run compares two differently parameterised instances against a brightness model.
module tb_led_trail_fader;

    localparam int PD0 = 1;
    localparam int DS0 = 1;
    localparam int PD1 = 3;
    localparam int DS1 = 2;

    logic        clk;
    logic        rst;
    logic        step_clk;
    logic [11:0] pattern_in;
    logic [11:0] led_out;
    logic        step_pulse;
    logic [11:0] led_out_b;
    logic        step_pulse_b;

    int passCount;
    int checkCount;

    led_trail_fader #(.N_LEDS(12), .LVL_W(4), .DECAY_SHIFT(DS0), .PWM_DIV(PD0)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_clk   (step_clk),
        .pattern_in (pattern_in),
        .led_out    (led_out),
        .step_pulse (step_pulse)
    );

    led_trail_fader #(.N_LEDS(12), .LVL_W(4), .DECAY_SHIFT(DS1), .PWM_DIV(PD1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .step_clk   (step_clk),
        .pattern_in (pattern_in),
        .led_out    (led_out_b),
        .step_pulse (step_pulse_b)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Brightness model built from the behavioural rules.
    // Levels are integers divided by 2^shift on each step.
    // The PWM count is the number of cycles since reset divided by PWM_DIV, modulo 16.
    int          mLvl [2][12];
    int          mCyc;
    logic [11:0] expLed [2];
    logic        expPulse;
    logic        prevStep;

    always @(posedge clk) begin
        bit rise;
        int pd;
        int ds;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 12; i++) mLvl[d][i] = 0;
                expLed[d] = '0;
            end
            mCyc     = 0;
            expPulse = 1'b0;
            prevStep = 1'b0;
        end else begin
            rise     = step_clk && !prevStep;
            expPulse = rise;
            for (int d = 0; d < 2; d++) begin
                pd = (d == 0) ? PD0 : PD1;
                ds = (d == 0) ? DS0 : DS1;
                for (int i = 0; i < 12; i++) begin
                    expLed[d][i] = (mLvl[d][i] == 15) || (mLvl[d][i] > ((mCyc / pd) % 16));
                    if (pattern_in[i])
                        mLvl[d][i] = 15;
                    else if (rise)
                        mLvl[d][i] = mLvl[d][i] / (1 << ds);
                end
            end
            mCyc++;
            prevStep = step_clk;
        end
    end

    // Put both instances into a clean state.
    task automatic doReset();
        rst        = 1'b1;
        pattern_in = '0;
        step_clk   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset clears the outputs, and a lit pattern shows up two cycles after release.
    task automatic test_reset();
        rst        = 1'b1;
        pattern_in = 12'h060;
        step_clk   = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++;
        if (led_out !== 12'h000) $display("[TB] FAIL reset_led_out got %h want 000", led_out);
        else passCount++;
        checkCount++;
        if (step_pulse !== 1'b0) $display("[TB] FAIL reset_step_pulse got %b want 0", step_pulse);
        else passCount++;
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if (led_out[6:5] !== 2'b00) $display("[TB] FAIL latency_cycle1 got %b want 00", led_out[6:5]);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (led_out[6:5] !== 2'b11) $display("[TB] FAIL latency_cycle2 got %b want 11", led_out[6:5]);
        else passCount++;
    endtask

    // Each step halves a dark LED's level; a 16-cycle window shows that many on cycles.
    task automatic test_decay();
        int want [4] = '{7, 3, 1, 0};
        int cnt;
        doReset();
        pattern_in = 12'h001;
        repeat (5) @(negedge clk);
        pattern_in = 12'h000;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step_clk = 1'b1;
            @(negedge clk);
            cnt = 0;
            repeat (16) begin
                @(negedge clk);
                if (led_out[0] === 1'b1) cnt++;
            end
            checkCount++;
            if (cnt !== want[k]) $display("[TB] FAIL decay_window%0d got %0d want %0d", k, cnt, want[k]);
            else passCount++;
            step_clk = 1'b0;
            @(negedge clk);
        end
    endtask

    // A held pattern bit stays fully on with no PWM gap, even across steps.
    task automatic test_full_on();
        doReset();
        pattern_in = 12'h008;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (k == 10 || k == 25) step_clk = 1'b1;
            if (k == 14 || k == 29) step_clk = 1'b0;
            @(negedge clk);
            checkCount++;
            if (led_out[3] !== 1'b1) $display("[TB] FAIL full_on_cycle%0d got %b want 1", k, led_out[3]);
            else passCount++;
        end
    endtask

    // A step that coincides with a pattern bit gives full brightness, not a decayed level.
    task automatic test_simultaneous();
        int cnt;
        doReset();
        pattern_in = 12'h800;
        repeat (2) @(negedge clk);
        pattern_in = 12'h000;
        for (int k = 0; k < 2; k++) begin
            step_clk = 1'b1;
            @(negedge clk);
            step_clk = 1'b0;
            @(negedge clk);
        end
        step_clk   = 1'b1;
        pattern_in = 12'h800;
        @(negedge clk);
        pattern_in = 12'h000;
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (led_out[11] === 1'b1) cnt++;
        end
        checkCount++;
        if (cnt !== 16) $display("[TB] FAIL simultaneous_on_cycles got %0d want 16", cnt);
        else passCount++;
        step_clk = 1'b0;
    endtask

    // A held-high step level strobes once; a 4-high/4-low toggle strobes once per 8 cycles.
    task automatic test_step_edge();
        int cnt;
        doReset();
        step_clk = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (step_pulse === 1'b1) cnt++;
        end
        checkCount++;
        if (cnt !== 1) $display("[TB] FAIL step_held_pulses got %0d want 1", cnt);
        else passCount++;
        step_clk = 1'b0;
        repeat (4) @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 64; k++) begin
            step_clk = (((k / 4) % 2) == 0);
            @(negedge clk);
            if (step_pulse === 1'b1) cnt++;
        end
        checkCount++;
        if (cnt !== 8) $display("[TB] FAIL step_toggle_pulses got %0d want 8", cnt);
        else passCount++;
        step_clk = 1'b0;
    endtask

    // Reset in the middle of a fade dims everything at once, and the PWM timebase restarts.
    task automatic test_reset_mid_fade();
        doReset();
        pattern_in = 12'h001;
        repeat (2) @(negedge clk);
        pattern_in = 12'h000;
        step_clk = 1'b1; @(negedge clk); step_clk = 1'b0;
        pattern_in = 12'h002;
        repeat (2) @(negedge clk);
        pattern_in = 12'h000;
        step_clk = 1'b1; @(negedge clk); step_clk = 1'b0;
        pattern_in = 12'h004;
        repeat (3) @(negedge clk);
        checkCount++;
        if (led_out !== expLed[0]) $display("[TB] FAIL mid_fade_setup got %h want %h", led_out, expLed[0]);
        else passCount++;
        pattern_in = 12'h000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkCount++;
        if (led_out !== 12'h000) $display("[TB] FAIL mid_fade_reset_led got %h want 000", led_out);
        else passCount++;
        checkCount++;
        if (dut.pwmCnt_q !== 4'd0 || dut.prescale_q !== 1'b0)
            $display("[TB] FAIL mid_fade_reset_timebase got pwm=%0d pre=%0d want 0/0", dut.pwmCnt_q, dut.prescale_q);
        else passCount++;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checkCount++;
            if (led_out !== 12'h000) $display("[TB] FAIL mid_fade_dark_cycle%0d got %h want 000", k, led_out);
            else passCount++;
        end
    endtask

    // Random sparse patterns, random steps and occasional resets, checked against the model.
    task automatic test_random();
        doReset();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0)
                pattern_in = 12'h001 << $urandom_range(0, 11);
            else if ($urandom_range(0, 31) == 0)
                pattern_in = 12'(($urandom & 32'h0FFF) & ($urandom & 32'h0FFF));
            else
                pattern_in = 12'h000;
            if ($urandom_range(0, 5) == 0) step_clk = ~step_clk;
            @(negedge clk);
            checkCount++;
            if (led_out !== expLed[0]) $display("[TB] FAIL rand_led_a cyc%0d got %h want %h", k, led_out, expLed[0]);
            else passCount++;
            checkCount++;
            if (led_out_b !== expLed[1]) $display("[TB] FAIL rand_led_b cyc%0d got %h want %h", k, led_out_b, expLed[1]);
            else passCount++;
            checkCount++;
            if (step_pulse !== expPulse) $display("[TB] FAIL rand_pulse cyc%0d got %b want %b", k, step_pulse, expPulse);
            else passCount++;
        end
        rst = 1'b0;
    endtask

    // Run every scenario in turn, then report.
    initial begin
        passCount  = 0;
        checkCount = 0;
        rst        = 1'b1;
        pattern_in = '0;
        step_clk   = 1'b0;
        $display("[TB] starting led_trail_fader bench");
        test_reset();
        test_decay();
        test_full_on();
        test_simultaneous();
        test_step_edge();
        test_reset_mid_fade();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
